// File: rtl/jtgaiden_wildfang_prot.sv
// ---------------------------------------------------------------------------
// jtgaiden_wildfang_prot
//
// Stand-in for the Wild Fang protection MCU as the main 68000 sees it. The CPU
// writes command bytes (upper nibble = command, lower nibble = argument) to
// the protection port. The commands build a jump-table index, start a fetch
// from the external jump-address LUT, and read back the 16-bit result one
// tagged nibble at a time.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_prot_we    CPU write strobe (level; one command per rising edge)
//   i_din        CPU data D15-D8: [7:4] command, [3:0] argument
//   o_dout       protection read value
//   o_busy       high while a LUT fetch is in flight
//   o_lut_addr   index into the jump LUT
//   i_lut_jump   LUT data, valid LUT_LAT cycles after o_lut_addr changes
//   o_dbg_state  current FSM state (0 = IDLE, 1 = FETCH)
//
// Handshake: there is no valid/ready pair. A command is accepted in the
// cycle where i_prot_we is high and was low the cycle before; i_din is
// sampled in that same cycle and the result shows on o_dout one cycle later.
// ---------------------------------------------------------------------------
module jtgaiden_wildfang_prot #(
    parameter int LUT_SIZE = 17,
    parameter int LUT_LAT  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_prot_we,
    input  logic [7:0]  i_din,
    output logic [7:0]  o_dout,
    output logic        o_busy,
    output logic [4:0]  o_lut_addr,
    input  logic [15:0] i_lut_jump,
    output logic        o_dbg_state
);

    localparam int         CW      = $clog2(LUT_LAT + 1) + 1;
    localparam logic [8:0] SIZE9   = 9'(LUT_SIZE);
    localparam logic [CW-1:0] LAST = CW'(LUT_LAT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t        r_state,   w_state_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;
    logic [7:0]    r_index,   w_index_nxt;
    logic [15:0]   r_jump,    w_jump_nxt;
    logic [7:0]    r_dout,    w_dout_nxt;
    logic [4:0]    r_addr,    w_addr_nxt;
    logic          r_prev_we;

    logic       w_edge;
    logic [3:0] w_cmd;
    logic [3:0] w_arg;
    logic [7:0] w_low_idx;
    logic [3:0] w_nib;

    assign w_edge    = i_prot_we & ~r_prev_we;
    assign w_cmd     = i_din[7:4];
    assign w_arg     = i_din[3:0];
    assign w_low_idx = {r_index[7:4], w_arg};

    // Nibble of the latched jump address selected by read commands 3..6.
    always_comb begin
        w_nib = 4'h0;
        case (w_cmd)
            4'h3:    w_nib = r_jump[15:12];
            4'h4:    w_nib = r_jump[11:8];
            4'h5:    w_nib = r_jump[7:4];
            4'h6:    w_nib = r_jump[3:0];
            default: w_nib = 4'h0;
        endcase
    end

    // Next-state logic. Fetch progress is evaluated first so that a command
    // arriving in the same cycle can override it (abort or restart).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_index_nxt = r_index;
        w_jump_nxt  = r_jump;
        w_dout_nxt  = r_dout;
        w_addr_nxt  = r_addr;

        // The LUT output is registered, so data for an address set at the
        // command edge is sampled LUT_LAT+1 edges later.
        if (r_state == ST_FETCH) begin
            if (r_cnt == LAST) begin
                w_jump_nxt  = i_lut_jump;
                w_state_nxt = ST_IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end

        if (w_edge) begin
            case (w_cmd)
                4'h0: begin
                    w_dout_nxt  = 8'h00;
                    w_index_nxt = 8'h00;
                    w_state_nxt = ST_IDLE;
                    w_jump_nxt  = r_jump;
                end
                4'h1: begin
                    w_dout_nxt  = 8'h10;
                    w_index_nxt = {w_arg, 4'h0};
                    w_state_nxt = ST_IDLE;
                    w_jump_nxt  = r_jump;
                end
                4'h2: begin
                    w_dout_nxt  = 8'h20;
                    w_index_nxt = w_low_idx;
                    // Range check covers all 8 bits; only [4:0] is wired out.
                    w_addr_nxt  = ({1'b0, w_low_idx} >= SIZE9) ? 5'd0 : w_low_idx[4:0];
                    w_state_nxt = ST_FETCH;
                    w_cnt_nxt   = '0;
                    w_jump_nxt  = r_jump;
                end
                4'h3, 4'h4, 4'h5, 4'h6: begin
                    w_dout_nxt = {w_cmd + 4'd1, w_nib};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        // Tracks the strobe even in reset so a strobe held through reset
        // release is not seen as a new edge.
        r_prev_we <= i_prot_we;
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_index <= 8'h00;
            r_jump  <= 16'h0000;
            r_dout  <= 8'h00;
            r_addr  <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_index <= w_index_nxt;
            r_jump  <= w_jump_nxt;
            r_dout  <= w_dout_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    assign o_dout      = r_dout;
    assign o_busy      = (r_state == ST_FETCH);
    assign o_lut_addr  = r_addr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jtgaiden_wildfang_prot.sv
module tb_jtgaiden_wildfang_prot;

    localparam int LUT_SIZE = 17;
    localparam int LUT_LAT  = 1;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        prot_we;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        busy;
    logic [4:0]  lut_addr;
    logic [15:0] lut_jump;
    logic        dbg_state;

    always #5 clk = ~clk;

    jtgaiden_wildfang_prot #(.LUT_SIZE(LUT_SIZE), .LUT_LAT(LUT_LAT)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_prot_we  (prot_we),
        .i_din      (din),
        .o_dout     (dout),
        .o_busy     (busy),
        .o_lut_addr (lut_addr),
        .i_lut_jump (lut_jump),
        .o_dbg_state(dbg_state)
    );

    // Registered jump LUT with LUT_LAT cycles of latency.
    logic [15:0] lut_mem  [32];
    logic [15:0] lut_pipe [LUT_LAT];

    always @(posedge clk) begin
        lut_pipe[0] <= lut_mem[lut_addr];
        for (int i = 1; i < LUT_LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
    end
    assign lut_jump = lut_pipe[LUT_LAT-1];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Settled-state model: what dout/lut_addr/jump are once a write and any
    // fetch it starts have completed.
    logic [7:0]  m_index;
    logic [15:0] m_jump;
    logic [7:0]  m_dout;
    logic [4:0]  m_addr;

    function automatic void model_reset();
        m_index = 0; m_jump = 0; m_dout = 0; m_addr = 0;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        int cmd = int'(d[7:4]);
        int a   = int'(d[3:0]);
        int eff;
        case (cmd)
            0: begin m_dout = 8'h00; m_index = 8'h00; end
            1: begin m_dout = 8'h10; m_index = 8'(a * 16); end
            2: begin
                m_dout  = 8'h20;
                m_index = 8'((int'(m_index) / 16) * 16 + a);
                eff     = (int'(m_index) < LUT_SIZE) ? int'(m_index) : 0;
                m_addr  = 5'(eff);
                m_jump  = lut_mem[eff];
            end
            3, 4, 5, 6: m_dout = 8'((cmd + 1) * 16 + ((int'(m_jump) >> (4 * (6 - cmd))) % 16));
            default: ;
        endcase
    endfunction

    // ---------------- driver ----------------
    // One-cycle strobe pulse; returns the number of cycles busy was seen high
    // afterwards, starting with the first cycle after the command edge.
    task automatic run_cmd(input logic [7:0] d, output int busy_cycles);
        @(negedge clk); prot_we = 1'b1; din = d;
        @(negedge clk); prot_we = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 32) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
        logic [4:0] addr;
        int         busy;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int cmd;
        logic [7:0] d;

        for (int i = 0; i < 32; i++) lut_mem[i] = 16'($urandom);
        lut_mem[0]  = 16'h0c0c;
        lut_mem[3]  = 16'ha5c3;
        lut_mem[5]  = 16'h112e;
        lut_mem[16] = 16'h1b52;
        for (int i = 0; i < LUT_LAT; i++) lut_pipe[i] = 16'h0;
        model_reset();

        // Reset with the strobe held high and an index-low command on the bus.
        rst = 1'b1; prot_we = 1'b1; din = 8'h25;
        repeat (3) @(negedge clk);
        check("rst_dout", 16'(dout), 16'h00);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_addr", 16'(lut_addr), 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("held_we_dout", 16'(dout), 16'h00);
        check("held_we_busy", 16'(busy), 16'h0);
        check("held_we_addr", 16'(lut_addr), 16'h0);
        prot_we = 1'b0;
        @(negedge clk);

        // Directed vectors.
        vecs.push_back('{8'h00, 8'h00, 5'd0,  0});
        vecs.push_back('{8'h10, 8'h10, 5'd0,  0});
        vecs.push_back('{8'h25, 8'h20, 5'd5,  LUT_LAT + 1});
        vecs.push_back('{8'h30, 8'h41, 5'd5,  0});
        vecs.push_back('{8'h40, 8'h51, 5'd5,  0});
        vecs.push_back('{8'h50, 8'h62, 5'd5,  0});
        vecs.push_back('{8'h60, 8'h7e, 5'd5,  0});
        vecs.push_back('{8'h11, 8'h10, 5'd5,  0});
        vecs.push_back('{8'h20, 8'h20, 5'd16, LUT_LAT + 1});
        vecs.push_back('{8'h30, 8'h41, 5'd16, 0});
        vecs.push_back('{8'h40, 8'h5b, 5'd16, 0});
        vecs.push_back('{8'h50, 8'h65, 5'd16, 0});
        vecs.push_back('{8'h60, 8'h72, 5'd16, 0});
        vecs.push_back('{8'h11, 8'h10, 5'd16, 0});
        vecs.push_back('{8'h21, 8'h20, 5'd0,  LUT_LAT + 1});
        vecs.push_back('{8'h30, 8'h40, 5'd0,  0});
        vecs.push_back('{8'h40, 8'h5c, 5'd0,  0});
        vecs.push_back('{8'h50, 8'h60, 5'd0,  0});
        vecs.push_back('{8'h60, 8'h7c, 5'd0,  0});

        foreach (vecs[i]) begin
            run_cmd(vecs[i].din, bc);
            model_write(vecs[i].din);
            check($sformatf("vec%0d_dout", i), 16'(dout), 16'(vecs[i].dout));
            check($sformatf("vec%0d_addr", i), 16'(lut_addr), 16'(vecs[i].addr));
            check($sformatf("vec%0d_busy_len", i), 16'(bc), 16'(vecs[i].busy));
        end

        // Strobe held high: only the first edge executes, later din ignored.
        @(negedge clk); prot_we = 1'b1; din = 8'h30;
        repeat (10) @(negedge clk);
        din = 8'h60;
        repeat (10) @(negedge clk);
        prot_we = 1'b0;
        @(negedge clk);
        model_write(8'h30);
        check("hold_dout", 16'(dout), 16'(m_dout));
        check("hold_dout_const", 16'(dout), 16'h40);
        run_cmd(8'h90, bc);
        check("ignored_dout", 16'(dout), 16'h40);
        check("ignored_busy", 16'(bc), 16'h0);

        // Fetch aborted by init arriving as early as the strobe allows.
        run_cmd(8'h10, bc);
        model_write(8'h10);
        @(negedge clk); prot_we = 1'b1; din = 8'h23;
        @(negedge clk); prot_we = 1'b0;
        check("abort_busy_mid", 16'(busy), 16'h1);
        check("abort_addr", 16'(lut_addr), 16'h3);
        @(negedge clk); prot_we = 1'b1; din = 8'h00;
        @(negedge clk); prot_we = 1'b0;
        m_addr = 5'd3;
        model_write(8'h00);
        check("abort_busy", 16'(busy), 16'h0);
        check("abort_dout", 16'(dout), 16'h00);
        repeat (4) @(negedge clk);
        check("abort_busy_later", 16'(busy), 16'h0);
        for (int k = 3; k <= 6; k++) begin
            d = 8'(k * 16);
            run_cmd(d, bc);
            model_write(d);
            check($sformatf("abort_jump_nib%0d", k), 16'(dout), 16'(m_dout));
        end

        // Randomized command stream against the model.
        for (int it = 0; it < 80; it++) begin
            cmd = int'($urandom_range(0, 9));
            if (cmd == 1) d = 8'(16 + $urandom_range(0, 2));
            else          d = 8'(cmd * 16 + $urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_cmd(d, bc);
            model_write(d);
            check($sformatf("rnd%0d_dout_%0h", it, d), 16'(dout), 16'(m_dout));
            check($sformatf("rnd%0d_addr_%0h", it, d), 16'(lut_addr), 16'(m_addr));
            check($sformatf("rnd%0d_busy_%0h", it, d), 16'(bc), 16'((cmd == 2) ? LUT_LAT + 1 : 0));
        end

        // Reset in the middle of a fetch.
        run_cmd(8'h10, bc);
        @(negedge clk); prot_we = 1'b1; din = 8'h25;
        @(negedge clk); prot_we = 1'b0;
        check("rstfetch_busy_before", 16'(busy), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rstfetch_dout", 16'(dout), 16'h00);
        check("rstfetch_busy", 16'(busy), 16'h0);
        check("rstfetch_addr", 16'(lut_addr), 16'h0);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rstfetch_busy_after", 16'(busy), 16'h0);
        run_cmd(8'h30, bc);
        model_write(8'h30);
        check("rstfetch_jump_hi", 16'(dout), 16'h40);
        run_cmd(8'h60, bc);
        model_write(8'h60);
        check("rstfetch_jump_lo", 16'(dout), 16'(m_dout));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtgaiden_wildfang_prot.md
Name: jtgaiden_wildfang_prot

Overview:
- Models the Wild Fang protection MCU as seen by the main 68000.
- Decodes the CPU's command writes (init, jump index high/low nibble, nibble fetch) and drives the 5-bit index into the jump-address LUT.
- Returns the 16-bit jump address to the CPU one tagged nibble at a time.
- Sits between the main CPU bus decoder and the jump-address LUT, whose output is registered.

Parameters:
- LUT_SIZE, 17, number of valid LUT entries; any index at or above this value is replaced by 0.
- LUT_LAT, 1, LUT read latency in clk cycles (address in to data valid).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- prot_we  in  1  CPU write strobe to the protection port; level signal, may stay high for many cycles
- din  in  8  CPU data high byte (D15-D8); bits 7-4 are the command, bits 3-0 are the argument
- dout  out  8  protection read value, driven continuously
- busy  out  1  high while a LUT fetch is in flight
- lut_addr  out  5  index to the jump LUT
- lut_jump  in  16  LUT data, valid LUT_LAT cycles after lut_addr changes

Behaviour:
- Reset values: dout=8'h00, busy=0, lut_addr=0. The internal index, jump latch and state are also cleared. Reset takes priority over all other activity, including a write in the same cycle or a fetch in flight.
- Write detection:
  - A command executes only on the rising edge of prot_we, registered as prev_we.
  - A strobe held high executes once.
  - din is sampled in the edge cycle.
- Command decode on din[7:4] (a = din[3:0]):
  - 0x0 (init): dout<=8'h00; index<=0.
  - 0x1 (index high): index[7:4]<=a; index[3:0]<=0; dout<=8'h10.
  - 0x2 (index low): index[3:0]<=a; dout<=8'h20.
    - If {index[7:4],a} >= LUT_SIZE, the effective index is 0.
    - lut_addr<=effective index[4:0]; enter FETCH; busy<=1.
  - 0x3: dout<=8'h40 | jump[15:12].
  - 0x4: dout<=8'h50 | jump[11:8].
  - 0x5: dout<=8'h60 | jump[7:4].
  - 0x6: dout<=8'h70 | jump[3:0].
  - 0x7-0xF: ignored; dout and state are unchanged.
- State machine:
  - IDLE -> FETCH on a 0x2 command.
  - FETCH counts LUT_LAT cycles. On the count's last cycle: jump<=lut_jump; busy<=0; go to IDLE.
  - The total time from the 0x2 edge to the jump latch update is LUT_LAT+1 cycles.
- Commands arriving during FETCH:
  - 0x0 and 0x1 abort the fetch (busy<=0, jump unchanged) and then execute normally.
  - 0x2 restarts the fetch with the new index.
  - 0x3-0x6 execute against the old jump value.
- dout latency: dout updates one cycle after the edge cycle and holds until the next valid command.
- jump holds its last fetched value through init. Only a completed fetch or rst changes it.
- Only index[4:0] reaches lut_addr. The range check uses all 8 index bits.

Test Plan:
- Reset with prot_we held high, then release rst -> no command executes until prot_we falls and rises again; dout=00, busy=0.
- Write 0x00, 0x10, 0x25 with lut_jump model returning 16'h112e for index 5 -> lut_addr=5; busy high for LUT_LAT+1 cycles; dout=0x20.
  - Then 0x30/0x40/0x50/0x60 -> dout=0x41, 0x51, 0x62, 0x7e.
- Write 0x11, 0x20 (index 0x10) -> lut_addr=16; model value 16'h1b52 yields nibble reads 0x41, 0x5b, 0x65, 0x72.
- Write 0x11, 0x21 (index 0x11 >= 17) -> lut_addr=0; model 16'h0c0c yields 0x40, 0x5c, 0x60, 0x7c.
- Hold prot_we high 20 cycles with din=0x30 -> exactly one execution; write 0x90 -> dout unchanged.
- Issue 0x23, then 0x00 the cycle after -> fetch aborted, busy=0, jump keeps previous value, dout=0x00. Separately, assert rst mid-FETCH -> all outputs return to reset values next cycle.
